cpu_ml: RTL and testbench

Parametrised multicycle CPU core: next generation of the 8-bit fetch/decode/execute core. Data width, register count, address width and reset vector are generic. Instruction and data use separate request/acknowledge ports, so memories with any number of wait states can be attached. Adds Z/C flags, conditional branches and a sticky halt status. Sits between the program ROM and the data RAM/peripheral bus in the top level.

---
 rtl/cpu_ml.sv | 161 ++++++++++++++++
 tb/tb_cpu_ml.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ml.sv
// cpu_ml: parametrised multicycle fetch/exec/mem core with Z/C flags, conditional branches
// and independent request/acknowledge instruction and data ports.
module cpu_ml #(
  parameter int unsigned   DW           = 8,
  parameter int unsigned   AW           = 16,
  parameter int unsigned   NREGS        = 16,
  parameter logic [AW-1:0] RESET_VECTOR = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] i_addr,
  output logic          i_req,
  input  logic [31:0]   i_data,
  input  logic          i_ack,
  output logic [AW-1:0] d_addr,
  output logic          d_req,
  output logic          d_we,
  output logic [DW-1:0] d_wdata,
  input  logic [DW-1:0] d_rdata,
  input  logic          d_ack,
  output logic          halted
);
  localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalted} state_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [31:0]   r_ir, w_ir_nxt;
  logic          r_z, w_z_nxt;
  logic          r_c, w_c_nxt;
  logic [DW-1:0] r_regs [NREGS];

  logic          w_rf_we;
  logic [DW-1:0] w_rf_wdata;
  logic [7:0]    w_op;
  logic [RW-1:0] w_rd, w_ra, w_rb;
  logic [DW-1:0] w_opd, w_opa, w_opb, w_alu;
  logic [DW:0]   w_sum, w_diff;
  logic          w_cout;
  logic [AW-1:0] w_target, w_pc_inc;

  assign w_op     = r_ir[31:24];
  assign w_rd     = r_ir[16 +: RW];
  assign w_ra     = r_ir[8 +: RW];
  assign w_rb     = r_ir[0 +: RW];
  assign w_opd    = r_regs[w_rd];
  assign w_opa    = r_regs[w_ra];
  assign w_opb    = r_regs[w_rb];
  assign w_target = AW'(r_ir[23:8]);
  assign w_pc_inc = r_pc + AW'(4);
  assign w_sum    = {1'b0, w_opa} + {1'b0, w_opb};
  assign w_diff   = {1'b0, w_opa} - {1'b0, w_opb};

  // Shifting by the full r[b] value naturally yields zero once the amount reaches DW.
  always_comb begin
    w_alu  = '0;
    w_cout = 1'b0;
    case (w_op)
      8'h05: begin
        w_alu  = w_sum[DW-1:0];
        w_cout = w_sum[DW];
      end
      8'h06: begin
        w_alu  = w_diff[DW-1:0];
        w_cout = w_diff[DW];
      end
      8'h07:   w_alu = w_opa & w_opb;
      8'h08:   w_alu = w_opa | w_opb;
      8'h09:   w_alu = w_opa ^ w_opb;
      8'h0A:   w_alu = w_opa << w_opb;
      8'h0B:   w_alu = w_opa >> w_opb;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_z_nxt     = r_z;
    w_c_nxt     = r_c;
    w_rf_we     = 1'b0;
    w_rf_wdata  = w_alu;
    case (r_state)
      StFetch: begin
        if (i_ack) begin
          w_ir_nxt    = i_data;
          w_state_nxt = StExec;
        end
      end
      StExec: begin
        w_state_nxt = StFetch;
        w_pc_nxt    = w_pc_inc;
        case (w_op)
          8'h00: begin
            w_state_nxt = StHalted;
            w_pc_nxt    = r_pc;
          end
          8'h01, 8'h02: w_state_nxt = StMem;
          8'h03: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = DW'(r_ir[15:8]);
          end
          8'h04: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_opa;
          end
          8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B: begin
            w_rf_we = 1'b1;
            w_z_nxt = (w_alu == '0);
            w_c_nxt = w_cout;
          end
          8'h0C: w_pc_nxt = w_target;
          8'h0D: if (r_z) w_pc_nxt = w_target;
          8'h0E: if (!r_z) w_pc_nxt = w_target;
          8'h0F: if (r_c) w_pc_nxt = w_target;
          default: ;
        endcase
      end
      StMem: begin
        if (d_ack) begin
          w_state_nxt = StFetch;
          if (w_op == 8'h01) begin
            w_rf_we    = 1'b1;
            w_rf_wdata = d_rdata;
          end
        end
      end
      StHalted: ;
      default: w_state_nxt = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch;
      r_pc    <= RESET_VECTOR;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_z     <= w_z_nxt;
      r_c     <= w_c_nxt;
      if (w_rf_we) r_regs[w_rd] <= w_rf_wdata;
    end
  end

  // Requests are masked during rst so an in-flight transfer is dropped immediately.
  assign i_addr  = r_pc;
  assign i_req   = (r_state == StFetch) && !rst;
  assign d_addr  = AW'(r_ir[15:0]);
  assign d_req   = (r_state == StMem) && !rst;
  assign d_we    = d_req && (w_op == 8'h02);
  assign d_wdata = w_opd;
  assign halted  = (r_state == StHalted) && !rst;
endmodule

// File: tb/tb_cpu_ml.sv
// Directed bench for cpu_ml: instruction tables driven through req/ack models, checked against
// hand-computed fetch addresses, store data and latencies.
module tb_cpu_ml;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst1, rst2, sel;
  logic [31:0] i_data;
  logic        i_ack, d_ack;
  logic [15:0] d_rdata;

  logic [15:0] i_addr1, d_addr1, i_addr2, d_addr2, d_wdata2;
  logic [7:0]  d_wdata1;
  logic        i_req1, d_req1, d_we1, halted1, i_req2, d_req2, d_we2, halted2;

  cpu_ml dut1 (
    .clk(clk), .rst(rst1), .i_addr(i_addr1), .i_req(i_req1), .i_data(i_data), .i_ack(i_ack),
    .d_addr(d_addr1), .d_req(d_req1), .d_we(d_we1), .d_wdata(d_wdata1), .d_rdata(d_rdata[7:0]),
    .d_ack(d_ack), .halted(halted1)
  );

  cpu_ml #(.DW(16), .NREGS(4)) dut2 (
    .clk(clk), .rst(rst2), .i_addr(i_addr2), .i_req(i_req2), .i_data(i_data), .i_ack(i_ack),
    .d_addr(d_addr2), .d_req(d_req2), .d_we(d_we2), .d_wdata(d_wdata2), .d_rdata(d_rdata),
    .d_ack(d_ack), .halted(halted2)
  );

  wire [15:0] m_i_addr  = sel ? i_addr2 : i_addr1;
  wire [15:0] m_d_addr  = sel ? d_addr2 : d_addr1;
  wire [15:0] m_d_wdata = sel ? d_wdata2 : {8'h00, d_wdata1};
  wire        m_i_req   = sel ? i_req2 : i_req1;
  wire        m_d_req   = sel ? d_req2 : d_req1;
  wire        m_d_we    = sel ? d_we2 : d_we1;
  wire        m_halted  = sel ? halted2 : halted1;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
    int          iwait;
    int          kind;   // 0 none, 1 store, 2 load
    logic [15:0] daddr;
    logic [15:0] dval;
    int          dwait;
  } vec_t;

  vec_t prog[$];
  int   errors = 0;
  int   checks = 0;
  int   last_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] pc, input logic [31:0] ins, input int iw);
    vec_t v;
    v = '{pc, ins, iw, 0, 16'h0, 16'h0, 0};
    return v;
  endfunction

  function automatic vec_t mkm(input logic [15:0] pc, input logic [31:0] ins, input int kind,
                               input logic [15:0] a, input logic [15:0] val, input int dw);
    vec_t v;
    v = '{pc, ins, 0, kind, a, val, dw};
    return v;
  endfunction

  task automatic do_fetch(input logic [15:0] pc, input logic [31:0] instr, input int iwait,
                          input int exp_lat);
    int n = 0;
    while (!m_i_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_lat > 0) check("fetch_latency", cyc - last_ack, exp_lat);
    check("i_req", {31'b0, m_i_req}, 1);
    check("i_addr", {16'b0, m_i_addr}, {16'b0, pc});
    for (int k = 0; k < iwait; k++) begin
      i_data  = 32'hFFFF_FFFF;
      d_ack   = k[0];   // stray data acks while fetching
      d_rdata = 16'hDEAD;
      @(negedge clk);
      check("i_addr_stable", {16'b0, m_i_addr}, {16'b0, pc});
      check("i_req_held", {31'b0, m_i_req}, 1);
    end
    d_ack    = 1'b0;
    i_data   = instr;
    i_ack    = 1'b1;
    last_ack = cyc;
    @(negedge clk);
    i_ack  = 1'b0;
    i_data = 32'h5A5A_5A5A;
  endtask

  task automatic do_mem(input int kind, input logic [15:0] a, input logic [15:0] val,
                        input int dwait);
    int n = 0;
    while (!m_d_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("d_req", {31'b0, m_d_req}, 1);
    check("d_addr", {16'b0, m_d_addr}, {16'b0, a});
    check("d_we", {31'b0, m_d_we}, (kind == 1) ? 32'd1 : 32'd0);
    if (kind == 1) check("d_wdata", {16'b0, m_d_wdata}, {16'b0, val});
    for (int k = 0; k < dwait; k++) begin
      @(negedge clk);
      check("d_req_held", {31'b0, m_d_req}, 1);
      check("d_addr_stable", {16'b0, m_d_addr}, {16'b0, a});
    end
    d_ack   = 1'b1;
    d_rdata = val;
    @(negedge clk);
    d_ack   = 1'b0;
    d_rdata = 16'hBEEF;
  endtask

  task automatic run_prog();
    int lat = 0;
    foreach (prog[i]) begin
      do_fetch(prog[i].pc, prog[i].instr, prog[i].iwait, lat);
      if (prog[i].kind != 0) do_mem(prog[i].kind, prog[i].daddr, prog[i].dval, prog[i].dwait);
      lat = ((prog[i].kind != 0) ? 3 : 2) + prog[i].dwait;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_bad;
    rst1 = 1'b1; rst2 = 1'b1; sel = 1'b0;
    i_data = '0; i_ack = 1'b0; d_ack = 1'b0; d_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_i_req", {31'b0, m_i_req}, 0);
    check("rst_d_req", {31'b0, m_d_req}, 0);
    check("rst_halted", {31'b0, m_halted}, 0);
    rst1 = 1'b0;
    @(negedge clk);

    prog.delete();
    prog.push_back(mk(16'h0000, 32'h0301C800, 0));                 // LDI r1,200
    prog.push_back(mk(16'h0004, 32'h03026400, 0));                 // LDI r2,100
    prog.push_back(mk(16'h0008, 32'h05030102, 0));                 // ADD r3=44 C=1
    prog.push_back(mk(16'h000C, 32'h0F002000, 0));                 // JC 0x20 taken
    prog.push_back(mk(16'h0020, 32'h0D008000, 0));                 // JZ not taken
    prog.push_back(mkm(16'h0024, 32'h02031234, 1, 16'h1234, 16'h002C, 3));
    prog.push_back(mk(16'h0028, 32'h06040202, 5));                 // SUB r4=0 Z=1, slow fetch
    prog.push_back(mk(16'h002C, 32'h0D004000, 0));                 // JZ 0x40 taken
    prog.push_back(mk(16'h0040, 32'h0E008000, 0));                 // JNZ falls through
    prog.push_back(mk(16'h0044, 32'h0F008000, 0));                 // JC falls through
    prog.push_back(mkm(16'h0048, 32'h02040010, 1, 16'h0010, 16'h0000, 0));
    prog.push_back(mkm(16'h004C, 32'h01051234, 2, 16'h1234, 16'h002C, 1));
    prog.push_back(mkm(16'h0050, 32'h02050020, 1, 16'h0020, 16'h002C, 0));
    prog.push_back(mk(16'h0054, 32'h03070900, 0));                 // LDI r7,9
    prog.push_back(mk(16'h0058, 32'h0A060107, 0));                 // SHL r6=0 Z=1
    prog.push_back(mk(16'h005C, 32'h0D010000, 0));                 // JZ 0x100 taken
    prog.push_back(mkm(16'h0100, 32'h02060030, 1, 16'h0030, 16'h0000, 0));
    prog.push_back(mk(16'h0104, 32'h03090300, 0));                 // LDI r9,3
    prog.push_back(mk(16'h0108, 32'h0B080109, 0));                 // SHR r8=25
    prog.push_back(mk(16'h010C, 32'h0E020000, 0));                 // JNZ 0x200 taken
    prog.push_back(mkm(16'h0200, 32'h02080040, 1, 16'h0040, 16'h0019, 0));
    prog.push_back(mk(16'h0204, 32'h090A0102, 0));                 // XOR r10=0xAC
    prog.push_back(mk(16'h0208, 32'h070B0102, 0));                 // AND r11=0x40
    prog.push_back(mk(16'h020C, 32'h080C0102, 0));                 // OR r12=0xEC
    prog.push_back(mk(16'h0210, 32'h040D0C00, 0));                 // MOV r13=r12
    prog.push_back(mkm(16'h0214, 32'h020A0050, 1, 16'h0050, 16'h00AC, 0));
    prog.push_back(mkm(16'h0218, 32'h020B0051, 1, 16'h0051, 16'h0040, 0));
    prog.push_back(mkm(16'h021C, 32'h020D0052, 1, 16'h0052, 16'h00EC, 0));
    prog.push_back(mk(16'h0220, 32'h05010101, 0));                 // ADD r1=r1+r1=0x90 C=1
    prog.push_back(mkm(16'h0224, 32'h02010060, 1, 16'h0060, 16'h0090, 0));
    prog.push_back(mk(16'h0228, 32'h0F030000, 0));                 // JC 0x300 taken
    prog.push_back(mk(16'h0300, 32'hFF000000, 0));                 // NOP
    prog.push_back(mk(16'h0304, 32'h0F040000, 0));                 // JC 0x400: C survives NOP
    prog.push_back(mk(16'h0400, 32'h00000000, 0));                 // HALT
    run_prog();

    // HALT: EXEC cycle now, halted the next cycle, then silence.
    check("halt_exec_halted", {31'b0, m_halted}, 0);
    @(negedge clk);
    check("halted_set", {31'b0, m_halted}, 1);
    check("halt_pc", {16'b0, m_i_addr}, 32'h0400);
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      i_ack = k[0];
      d_ack = k[1];
      @(negedge clk);
      if (m_i_req || m_d_req || !m_halted) idle_bad++;
    end
    i_ack = 1'b0; d_ack = 1'b0;
    check("halted_no_requests", idle_bad, 0);

    rst1 = 1'b1;
    @(negedge clk);
    check("rst_clears_halted", {31'b0, m_halted}, 0);
    check("rst_i_req_low", {31'b0, m_i_req}, 0);
    rst1 = 1'b0;
    @(negedge clk);
    check("restart_i_req", {31'b0, m_i_req}, 1);
    check("restart_pc", {16'b0, m_i_addr}, 32'h0000);

    // Reset in the middle of a load, with acks arriving during and after reset.
    do_fetch(16'h0000, 32'h01051234, 0, 0);
    begin
      int n = 0;
      while (!m_d_req && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    check("ld_d_req", {31'b0, m_d_req}, 1);
    rst1 = 1'b1;
    @(negedge clk);
    check("rst_drops_d_req", {31'b0, m_d_req}, 0);
    d_ack = 1'b1; d_rdata = 16'h0077;
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    d_ack = 1'b0;
    prog.delete();
    prog.push_back(mkm(16'h0000, 32'h02050001, 1, 16'h0001, 16'h0000, 0));  // r5 not loaded
    prog.push_back(mk(16'h0004, 32'h0CFFFC00, 0));                 // JMP 0xFFFC
    prog.push_back(mk(16'hFFFC, 32'hFF000000, 0));                 // NOP at top of memory
    prog.push_back(mk(16'h0000, 32'h00000000, 0));                 // wrapped to 0
    run_prog();

    // Wider datapath, fewer registers: d field 0x07 selects r3.
    rst1 = 1'b1; sel = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    prog.delete();
    prog.push_back(mk(16'h0000, 32'h0301C800, 0));
    prog.push_back(mk(16'h0004, 32'h03026400, 0));
    prog.push_back(mk(16'h0008, 32'h05070102, 0));                 // ADD r3=300 C=0
    prog.push_back(mk(16'h000C, 32'h0F008000, 0));                 // JC not taken
    prog.push_back(mk(16'h0010, 32'h0D008000, 0));                 // JZ not taken
    prog.push_back(mkm(16'h0014, 32'h02030005, 1, 16'h0005, 16'h012C, 0));
    prog.push_back(mk(16'h0018, 32'h00000000, 0));
    run_prog();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
